// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit 7-segment controller with serial decode, zero blanking and blink
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    hex_mode,
  input  logic                    blink_en,
  output logic                    ready,
  output logic                    err,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  // Index is fixed at 3 bits so a 1-digit build still has a legal width.
  localparam int IDX_W = 3;
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]       BLANK    = 7'b1111111;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t                    state;
  logic [4*NUM_DIGITS-1:0]   shadow;
  logic                      hex_q;
  logic [IDX_W-1:0]          idx;
  logic                      lz_flag;
  logic                      inv_flag;
  logic [7*NUM_DIGITS-1:0]   digits;
  logic [CNT_W-1:0]          blink_cnt;
  logic                      phase;

  logic [3:0]                cur_nib;
  logic [6:0]                glyph;
  logic                      nib_valid;
  logic                      nib_zero;
  logic                      lz_hit;
  logic [6:0]                dec_glyph;

  // Shared decoder: select the nibble at the current index and map it to a glyph.
  always_comb begin
    cur_nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_nib = shadow[4*i +: 4];
    end
    case (cur_nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
    nib_valid = hex_q | (cur_nib <= 4'd9);
    nib_zero  = (cur_nib == 4'd0);
    // Digit 0 always shows its value, so a zero reading stays visible.
    lz_hit    = (LZ_BLANK != 0) && lz_flag && nib_zero && (idx != '0);
    dec_glyph = (!nib_valid || lz_hit) ? BLANK : glyph;
  end

  // Conversion FSM: latch on load, then write one digit per cycle from the top down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      err      <= 1'b0;
      digits   <= '1;
      idx      <= '0;
      shadow   <= '0;
      hex_q    <= 1'b0;
      lz_flag  <= 1'b0;
      inv_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            state    <= S_CONV;
            ready    <= 1'b0;
            shadow   <= data_in;
            hex_q    <= hex_mode;
            idx      <= LAST_IDX;
            lz_flag  <= 1'b1;
            inv_flag <= 1'b0;
            err      <= 1'b0;
          end
        end
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) digits[7*i +: 7] <= dec_glyph;
          end
          if (nib_valid && !nib_zero) lz_flag <= 1'b0;
          if (!nib_valid) inv_flag <= 1'b1;
          if (idx == '0) begin
            state <= S_IDLE;
            ready <= 1'b1;
            err   <= inv_flag | ~nib_valid;
          end else begin
            idx <= idx - 1'b1;
          end
        end
      endcase
    end
  end

  // Blink prescaler: free-runs while enabled, toggling the phase on each wrap.
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign seg_out = phase ? '1 : digits;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - directed self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

  localparam int N = 4;

  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0111000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [27:0] ONES = 28'hFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        hex_mode;
  logic        blink_en;
  logic        ready;
  logic        err;
  logic [27:0] seg_out;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(4), .LZ_BLANK(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .hex_mode (hex_mode),
    .blink_en (blink_en),
    .ready    (ready),
    .err      (err),
    .seg_out  (seg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic hm);
    load     = 1'b1;
    data_in  = d;
    hex_mode = hm;
    tick();
    load     = 1'b0;
  endtask

  task automatic conv_done();
    repeat (N) tick();
  endtask

  logic [27:0] val;

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; hex_mode = 1'b0; blink_en = 1'b0;
    @(negedge clk);
    repeat (2) tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_err",   32'(err),   32'd0);
    check("rst_seg",   32'(seg_out), 32'(ONES));
    rst = 1'b0;

    // 1234 decimal: ready low for 4 samples, digit 3 first
    do_load(16'h1234, 1'b0);
    check("c1_rdy0", 32'(ready), 32'd0);
    check("c1_seg0", 32'(seg_out), 32'(ONES));
    tick();
    check("c1_rdy1", 32'(ready), 32'd0);
    check("c1_seg1", 32'(seg_out), 32'({G1, BL, BL, BL}));
    tick();
    check("c1_rdy2", 32'(ready), 32'd0);
    check("c1_seg2", 32'(seg_out), 32'({G1, G2, BL, BL}));
    tick();
    check("c1_rdy3", 32'(ready), 32'd0);
    check("c1_seg3", 32'(seg_out), 32'({G1, G2, G3, BL}));
    tick();
    check("c1_rdy4", 32'(ready), 32'd1);
    check("c1_seg",  32'(seg_out), 32'({G1, G2, G3, G4}));
    check("c1_err",  32'(err), 32'd0);

    // leading-zero blanking
    do_load(16'h0070, 1'b0);
    conv_done();
    check("lz_0070", 32'(seg_out), 32'({BL, BL, G7, G0}));
    do_load(16'h0000, 1'b0);
    conv_done();
    check("lz_0000", 32'(seg_out), 32'({BL, BL, BL, G0}));

    // invalid decimal vs hex glyphs
    do_load(16'h12AF, 1'b0);
    conv_done();
    check("dec_12af_seg", 32'(seg_out), 32'({G1, G2, BL, BL}));
    check("dec_12af_err", 32'(err), 32'd1);
    do_load(16'h12AF, 1'b1);
    conv_done();
    check("hex_12af_seg", 32'(seg_out), 32'({G1, G2, GA, GF}));
    check("hex_12af_err", 32'(err), 32'd0);

    // load during CONV is ignored
    do_load(16'h0056, 1'b0);
    tick();
    load = 1'b1; data_in = 16'h0099; hex_mode = 1'b1;
    tick();
    load = 1'b0;
    check("busy_rdy", 32'(ready), 32'd0);
    repeat (2) tick();
    check("busy_done", 32'(ready), 32'd1);
    check("busy_seg",  32'(seg_out), 32'({BL, BL, G5, G6}));

    // reset mid-conversion after an errored conversion
    do_load(16'h12AF, 1'b0);
    conv_done();
    check("pre_rst_err", 32'(err), 32'd1);
    do_load(16'h1234, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_seg", 32'(seg_out), 32'(ONES));
    check("mid_rst_rdy", 32'(ready), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);

    // reset beats a simultaneous load
    rst = 1'b1; load = 1'b1; data_in = 16'h1234; hex_mode = 1'b0;
    tick();
    rst = 1'b0; load = 1'b0;
    tick();
    check("rst_load_rdy", 32'(ready), 32'd1);
    check("rst_load_seg", 32'(seg_out), 32'(ONES));

    // blink: 4 visible / 4 blank after the initial partial period
    do_load(16'h1234, 1'b0);
    conv_done();
    val = {G1, G2, G3, G4};
    blink_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("blink_%0d", k), 32'(seg_out), ((k / 4) % 2 == 1) ? 32'(ONES) : 32'(val));
    end
    blink_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("steady_%0d", k), 32'(seg_out), 32'(val));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
